contador_bidir: RTL
===================

CONTADOR_BIDIR -- requirements
Module: contador_bidir

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter RST_VAL, default 0, value of s after reset (WIDTH bits).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port mode  input  2  count mode (mode_e: BOUNCE=0, WRAP_UP=1, WRAP_DN=2, HOLD=3).
REQ-007 SHALL have port lo  input  WIDTH  lower bound, inclusive.
REQ-008 SHALL have port hi  input  WIDTH  upper bound, inclusive.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  value loaded into s.
REQ-011 SHALL have port s  output  WIDTH  registered count.
REQ-012 SHALL have port dir  output  1  registered direction (0 = up, 1 = down).
REQ-013 SHALL have port at_lo / at_hi  output  1 each  combinational flags s==lo / s==hi.
REQ-014 SHALL have port turn  output  1  registered one-cycle pulse on reversal or wrap.
REQ-015 SHALL have port bnd_err  output  1  combinational flag lo>hi.

Function
REQ-016 SHALL use unsigned WIDTH-bit arithmetic; no state other than s, dir, turn (plus REQ-031 counter).
REQ-017 SHALL give priority per cycle: load > bnd_err > out-of-range clamp > en-driven count.
REQ-018 load=1 SHALL set s<=load_val regardless of en/mode/bounds, dir unchanged, turn<=0.
REQ-019 bnd_err=1 (no load) SHALL hold s and dir, turn<=0.
REQ-020 en=1 and s>hi SHALL set s<=hi; s<lo SHALL set s<=lo; dir unchanged, turn<=0.
REQ-021 en=0 (no load) SHALL hold s and dir, turn<=0.
REQ-022 BOUNCE, dir=0: s<hi -> s<=s+1; s==hi and hi>lo -> s<=hi-1, dir<=1, turn<=1.
REQ-023 BOUNCE, dir=1: s>lo -> s<=s-1; s==lo and hi>lo -> s<=lo+1, dir<=0, turn<=1.
REQ-024 BOUNCE SHALL therefore visit each bound for exactly one cycle per sweep (lo..hi..lo, period 2*(hi-lo)).
REQ-025 lo==hi in any counting mode SHALL hold s, turn<=0.
REQ-026 WRAP_UP SHALL force dir<=0; s<hi -> s+1; s==hi -> s<=lo, turn<=1.
REQ-027 WRAP_DN SHALL force dir<=1; s>lo -> s-1; s==lo -> s<=hi, turn<=1.
REQ-028 HOLD SHALL hold s and dir, turn<=0.
REQ-029 Full-range bounds (lo=0, hi=2^WIDTH-1) SHALL never overflow/underflow the adder: wrap and reversal come solely from REQ-022..027.

Reset
REQ-030 rst=0 SHALL immediately set s=RST_VAL, dir=0, turn=0 (and turns=0), independent of clk, and hold them while low; first update on first rising clk edge after rst release.

Configuration
REQ-031 With CONTADOR_TURN_CNT_EN defined, SHALL add output turns (16 bits), incremented when turn is set, saturating at 65535, cleared by reset and by load.
REQ-032 Without CONTADOR_TURN_CNT_EN, port turns SHALL not exist and no counter logic SHALL be synthesised.

Structure
REQ-033 Package contador_pkg SHALL hold typedef mode_e and constants DIR_UP=0, DIR_DN=1.
REQ-034 Combinational next-state logic (REQ-017..029) SHALL sit in sub-module contador_next; contador_bidir holds only registers, flags and the optional turns counter.

Verification (WIDTH=4, RST_VAL=0 unless noted)
REQ-035 BOUNCE lo=0 hi=15 en=1 from reset -> s 0,1..15,14..0,1; turn high one cycle after s=15 and after s=0; dir toggles each time.
REQ-036 WRAP_UP lo=3 hi=6 from s=0 -> s 3 (clamp, turn=0),4,5,6,3; turn=1 only with the 6->3 step; then WRAP_DN -> 6 after s=3.
REQ-037 Load priority: en=1, load=1, load_val=9, lo=12 hi=14 -> s=9 next cycle, then clamp to 12, then counting resumes.
REQ-038 lo=5 hi=5 -> s clamps to 5 and holds, turn=0; lo=8 hi=2 -> bnd_err=1, s and dir frozen.
REQ-039 rst asserted mid-sweep (s=7, dir=1) between clk edges -> s=0, dir=0, turn=0 before next edge; count restarts 1 on first edge after release.
REQ-040 With CONTADOR_TURN_CNT_EN, BOUNCE lo=0 hi=1 for 70000 cycles -> turns saturates at 65535; load -> turns=0.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types and constants for the bidirectional bounded counter.
// Holds the count-mode enum, direction encodings and the turn-counter helper.
// No logic of its own; imported by contador_next and contador_bidir.
package contador_pkg;

    // Count mode selected by the 2-bit mode input
    typedef enum logic [1:0] {
        BOUNCE  = 2'd0,
        WRAP_UP = 2'd1,
        WRAP_DN = 2'd2,
        HOLD    = 2'd3
    } mode_e;

    // Direction encodings carried by the dir register
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Width of the optional reversal/wrap event counter
    localparam int TURNS_W = 16;

    // Saturating increment for the event counter: sticks at all-ones
    function automatic logic [TURNS_W-1:0] sat_inc(input logic [TURNS_W-1:0] v);
        if (v == {TURNS_W{1'b1}}) begin
            return v;
        end
        return v + TURNS_W'(1);
    endfunction

endpackage

// File: rtl/contador_next.sv
// Next-state logic of the bounded counter: load, bound error, clamp, then count.
// Purely combinational, zero latency; result is registered by contador_bidir.
// No backpressure; a new decision is produced every cycle.
module contador_next
    import contador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] s,
    input  logic             dir,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             bnd_err,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] s_nxt,
    output logic             dir_nxt,
    output logic             turn_nxt
);

    mode_e mode_q;
    logic  span_zero;

    assign mode_q    = mode_e'(mode);
    // A zero-width window leaves nowhere to step to, so counting stalls
    assign span_zero = (lo == hi);

    // Priority chain: load, then bound error freeze, then clamp, then the mode step.
    // Increment only happens when s<hi and decrement only when s>lo, so the adder
    // can never wrap even with full-range bounds.
    always_comb begin
        s_nxt    = s;
        dir_nxt  = dir;
        turn_nxt = 1'b0;
        if (load) begin
            s_nxt = load_val;
        end else if (!bnd_err && en) begin
            if (s > hi) begin
                s_nxt = hi;
            end else if (s < lo) begin
                s_nxt = lo;
            end else begin
                case (mode_q)
                    BOUNCE: begin
                        if (!span_zero) begin
                            if (dir == DIR_UP) begin
                                if (s < hi) begin
                                    s_nxt = s + WIDTH'(1);
                                end else begin
                                    // Reflect off hi so it is visited only once per sweep
                                    s_nxt    = hi - WIDTH'(1);
                                    dir_nxt  = DIR_DN;
                                    turn_nxt = 1'b1;
                                end
                            end else begin
                                if (s > lo) begin
                                    s_nxt = s - WIDTH'(1);
                                end else begin
                                    s_nxt    = lo + WIDTH'(1);
                                    dir_nxt  = DIR_UP;
                                    turn_nxt = 1'b1;
                                end
                            end
                        end
                    end
                    WRAP_UP: begin
                        dir_nxt = DIR_UP;
                        if (!span_zero) begin
                            if (s < hi) begin
                                s_nxt = s + WIDTH'(1);
                            end else begin
                                s_nxt    = lo;
                                turn_nxt = 1'b1;
                            end
                        end
                    end
                    WRAP_DN: begin
                        dir_nxt = DIR_DN;
                        if (!span_zero) begin
                            if (s > lo) begin
                                s_nxt = s - WIDTH'(1);
                            end else begin
                                s_nxt    = hi;
                                turn_nxt = 1'b1;
                            end
                        end
                    end
                    default: begin
                        // HOLD: keep everything as is
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/contador_bidir.sv
// Bidirectional bounded up/down counter with bounce and wrap modes; optional
// turn event counter when CONTADOR_TURN_CNT_EN is defined. State updates one
// cycle after inputs; flags are combinational. No backpressure.
module contador_bidir
    import contador_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] s,
    output logic             dir,
    output logic             at_lo,
    output logic             at_hi,
    output logic             turn,
    output logic             bnd_err
`ifdef CONTADOR_TURN_CNT_EN
    ,
    output logic [TURNS_W-1:0] turns
`endif
);

    logic [WIDTH-1:0] s_nxt;
    logic             dir_nxt;
    logic             turn_nxt;

    // Status flags track the live bounds, not a registered copy
    assign at_lo   = (s == lo);
    assign at_hi   = (s == hi);
    assign bnd_err = (lo > hi);

    contador_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .s        (s),
        .dir      (dir),
        .en       (en),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
        .bnd_err  (bnd_err),
        .load     (load),
        .load_val (load_val),
        .s_nxt    (s_nxt),
        .dir_nxt  (dir_nxt),
        .turn_nxt (turn_nxt)
    );

    // Count, direction and turn pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s    <= RST_VAL;
            dir  <= DIR_UP;
            turn <= 1'b0;
        end else begin
            s    <= s_nxt;
            dir  <= dir_nxt;
            turn <= turn_nxt;
        end
    end

`ifdef CONTADOR_TURN_CNT_EN
    // Saturating count of turn pulses; load restarts the tally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            turns <= '0;
        end else if (load) begin
            turns <= '0;
        end else if (turn_nxt) begin
            turns <= sat_inc(turns);
        end
    end
`endif

endmodule
